// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU front end: next-PC selector codes,
// fetch FSM states and the default reset PC.
package cpu_pkg;

    localparam logic [1:0] NPC_SEQ  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_REG  = 2'b10;
    localparam logic [1:0] NPC_HOLD = 2'b11;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DONE = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch, register
// target, or hold. Kept stateless so pipelined variants can reuse it.
module npc_calc
    import cpu_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [1:0]      npc_op,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] ir_pc,
    input  logic [23:0]     imm24,
    input  logic [31:0]     rb_data,
    output logic [PC_W-1:0] npc
);

    logic [PC_W-1:0] br_offset;
    logic [31:0]     rb_aligned;

    always_comb begin
        // Branch target is relative to the fetch address plus 8 (ARM pipeline view).
        br_offset  = {{(PC_W-26){imm24[23]}}, imm24, 2'b00};
        rb_aligned = rb_data & 32'hFFFF_FFFC;
        npc        = pc;
        case (npc_op)
            NPC_SEQ:  npc = pc + PC_W'(4);
            NPC_BR:   npc = ir_pc + PC_W'(8) + br_offset;
            NPC_REG:  npc = rb_aligned[PC_W-1:0];
            default:  npc = pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC and instruction register and runs a
// req/ack fetch to instruction memory on request from the control block.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            IMen,
    input  logic            PCwr,
    input  logic [1:0]      NPCop,
    input  logic [31:0]     rb_data,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instruction,
    output logic            inst_valid,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_link
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [31:0]     ir_q, ir_d;
    logic [PC_W-1:0] ir_pc_q, ir_pc_d;
    logic            inst_valid_q, inst_valid_d;
    logic            req_q, req_d;
    logic [PC_W-1:0] npc;

    npc_calc #(
        .PC_W(PC_W)
    ) u_npc_calc (
        .npc_op  (NPCop),
        .pc      (pc_q),
        .ir_pc   (ir_pc_q),
        .imm24   (ir_q[23:0]),
        .rb_data (rb_data),
        .npc     (npc)
    );

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        ir_d         = ir_q;
        ir_pc_d      = ir_pc_q;
        inst_valid_d = inst_valid_q;
        req_d        = req_q;
        pc_d         = PCwr ? npc : pc_q;

        // The request runs from fetch_addr, so PC writes never disturb a fetch in flight.
        case (state_q)
            FETCH_IDLE: begin
                if (IMen) begin
                    fetch_addr_d = pc_q & ~PC_W'(3);
                    inst_valid_d = 1'b0;
                    req_d        = 1'b1;
                    state_d      = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    ir_pc_d = fetch_addr_q;
                    req_d   = 1'b0;
                    state_d = FETCH_DONE;
                end
            end
            FETCH_DONE: begin
                inst_valid_d = 1'b1;
                state_d      = FETCH_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH_IDLE;
            pc_q         <= RESET_PC[PC_W-1:0];
            fetch_addr_q <= '0;
            ir_q         <= 32'h0;
            ir_pc_q      <= '0;
            inst_valid_q <= 1'b0;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            ir_q         <= ir_d;
            ir_pc_q      <= ir_pc_d;
            inst_valid_q <= inst_valid_d;
            req_q        <= req_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = fetch_addr_q;
    assign instruction = ir_q;
    assign inst_valid  = inst_valid_q;
    assign pc          = pc_q;
    assign pc_link     = ir_pc_q + PC_W'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: fetch latency, PC update modes,
// fetch/PC-write overlap and reset in the middle of a fetch.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        IMen;
    logic        PCwr;
    logic [1:0]  NPCop;
    logic [31:0] rb_data;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_link;

    int checkCount = 0;
    int passCount  = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_W     (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .IMen        (IMen),
        .PCwr        (PCwr),
        .NPCop       (NPCop),
        .rb_data     (rb_data),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .inst_valid  (inst_valid),
        .pc          (pc),
        .pc_link     (pc_link)
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    endtask

    // Drives one cycle of inputs, then advances past the next rising edge.
    task automatic applyStimulus(input logic imen, input logic pcwr, input logic [1:0] op,
                                 input logic [31:0] rb, input logic ack, input logic [31:0] rdata);
        IMen       = imen;
        PCwr       = pcwr;
        NPCop      = op;
        rb_data    = rb;
        imem_ack   = ack;
        imem_rdata = rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 2'b11, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        idleCycle();
        idleCycle();
        rst = 1'b0;
        checkOutput("reset_pc", pc, 32'h0);
        checkOutput("reset_req", {31'b0, imem_req}, 32'h0);
        checkOutput("reset_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("reset_ir", instruction, 32'h0);
        checkOutput("reset_addr", imem_addr, 32'h0);
        checkOutput("reset_link", pc_link, 32'h4);

        // Fetch with one wait cycle: valid four cycles after IMen
        applyStimulus(1'b1, 1'b0, 2'b11, 32'h0, 1'b0, 32'h0);
        checkOutput("f1_req", {31'b0, imem_req}, 32'h1);
        checkOutput("f1_addr", imem_addr, 32'h0);
        idleCycle();
        checkOutput("f1_req_hold", {31'b0, imem_req}, 32'h1);
        applyStimulus(1'b0, 1'b0, 2'b11, 32'h0, 1'b1, 32'hE591_0AAA);
        checkOutput("f1_req_drop", {31'b0, imem_req}, 32'h0);
        checkOutput("f1_ir", instruction, 32'hE591_0AAA);
        checkOutput("f1_valid_early", {31'b0, inst_valid}, 32'h0);
        idleCycle();
        checkOutput("f1_valid", {31'b0, inst_valid}, 32'h1);

        // PC+4, then zero-wait fetch
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 32'h0);
        checkOutput("seq_pc", pc, 32'h4);
        applyStimulus(1'b1, 1'b0, 2'b11, 32'h0, 1'b0, 32'h0);
        checkOutput("f2_addr", imem_addr, 32'h4);
        checkOutput("f2_valid_clr", {31'b0, inst_valid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 2'b11, 32'h0, 1'b1, 32'hE1A0_0000);
        checkOutput("f2_valid_early", {31'b0, inst_valid}, 32'h0);
        idleCycle();
        checkOutput("f2_valid", {31'b0, inst_valid}, 32'h1);
        checkOutput("f2_link", pc_link, 32'h8);

        // Branch with negative offset fetched at 0x100
        applyStimulus(1'b0, 1'b1, 2'b10, 32'h0000_0100, 1'b0, 32'h0);
        checkOutput("reg_pc_100", pc, 32'h100);
        applyStimulus(1'b1, 1'b0, 2'b11, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 2'b11, 32'h0, 1'b1, 32'hEAFF_FF00);
        idleCycle();
        checkOutput("br_ir", instruction, 32'hEAFF_FF00);
        checkOutput("br_link", pc_link, 32'h104);
        applyStimulus(1'b0, 1'b1, 2'b01, 32'h0, 1'b0, 32'h0);
        checkOutput("br_pc", pc, 32'hFFFF_FD08);

        // Register target, hold, wrap-around
        applyStimulus(1'b0, 1'b1, 2'b10, 32'h0000_1237, 1'b0, 32'h0);
        checkOutput("reg_pc", pc, 32'h0000_1234);
        applyStimulus(1'b0, 1'b1, 2'b11, 32'hFFFF_FFFF, 1'b0, 32'h0);
        checkOutput("hold_pc", pc, 32'h0000_1234);
        applyStimulus(1'b0, 1'b1, 2'b10, 32'hFFFF_FFFC, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 32'h0);
        checkOutput("wrap_pc", pc, 32'h0);

        // PC write and extra IMen during WAIT
        applyStimulus(1'b0, 1'b1, 2'b10, 32'h0000_0200, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 2'b11, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 2'b00, 32'h0, 1'b0, 32'h0);
        checkOutput("ovl_addr", imem_addr, 32'h200);
        checkOutput("ovl_req", {31'b0, imem_req}, 32'h1);
        checkOutput("ovl_pc", pc, 32'h204);
        applyStimulus(1'b0, 1'b0, 2'b11, 32'h0, 1'b1, 32'h1111_1111);
        idleCycle();
        checkOutput("ovl_valid", {31'b0, inst_valid}, 32'h1);
        checkOutput("ovl_link", pc_link, 32'h204);
        checkOutput("ovl_no_refetch", {31'b0, imem_req}, 32'h0);

        // Stray ack in IDLE is dropped
        applyStimulus(1'b0, 1'b0, 2'b11, 32'h0, 1'b1, 32'hDEAD_BEEF);
        checkOutput("stale_ir", instruction, 32'h1111_1111);
        checkOutput("stale_req", {31'b0, imem_req}, 32'h0);

        // Reset in the middle of WAIT, late ack afterwards
        applyStimulus(1'b1, 1'b0, 2'b11, 32'h0, 1'b0, 32'h0);
        checkOutput("rw_req", {31'b0, imem_req}, 32'h1);
        rst = 1'b1;
        idleCycle();
        rst = 1'b0;
        checkOutput("rw_req_clr", {31'b0, imem_req}, 32'h0);
        checkOutput("rw_pc", pc, 32'h0);
        checkOutput("rw_ir", instruction, 32'h0);
        checkOutput("rw_valid", {31'b0, inst_valid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 2'b11, 32'h0, 1'b1, 32'hCAFE_BABE);
        checkOutput("rw_late_ir", instruction, 32'h0);
        idleCycle();
        checkOutput("rw_late_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("rw_link", pc_link, 32'h4);
        applyStimulus(1'b1, 1'b0, 2'b11, 32'h0, 1'b0, 32'h0);
        checkOutput("rw_idle_req", {31'b0, imem_req}, 32'h1);
        checkOutput("rw_idle_addr", imem_addr, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
